// File: rtl/uart_tx_arb_if.sv
// Handshake bundle between the two word requesters, the uart_tx transmitter and uart_tx_arb.
// The master modport is the requester/transmitter side; the slave modport is the arbiter.
interface uart_tx_arb_if #(
  parameter int WORD_WIDTH = 16
);
  logic                  req0_valid;
  logic [WORD_WIDTH-1:0] req0_word;
  logic                  req0_ack;
  logic                  req1_valid;
  logic [WORD_WIDTH-1:0] req1_word;
  logic                  req1_ack;
  logic                  tx_ready_to_send;
  logic                  tx_start_n;
  logic [7:0]            tx_data;
  logic                  busy;
  logic                  grant;
  logic                  timeout_err;

  modport master (
    output req0_valid, req0_word, req1_valid, req1_word, tx_ready_to_send,
    input  req0_ack, req1_ack, tx_start_n, tx_data, busy, grant, timeout_err
  );

  modport slave (
    input  req0_valid, req0_word, req1_valid, req1_word, tx_ready_to_send,
    output req0_ack, req1_ack, tx_start_n, tx_data, busy, grant, timeout_err
  );
endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that serialises 16-bit words from two requesters into uart_tx bytes, high byte first.
// Optional feature: define UART_ARB_TAG_EN to prefix each word with the tag byte 8'hA0 | grant.
module uart_tx_arb #(
  parameter int TIMEOUT_CYCLES = 16384
) (
  input  logic         clk,
  input  logic         rst,
  uart_tx_arb_if.slave bus
);
  localparam int WORD_WIDTH = 16;
`ifdef UART_ARB_TAG_EN
  localparam int NUM_BYTES = 3;
`else
  localparam int NUM_BYTES = 2;
`endif
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [1:0]       LAST_IDX  = 2'(NUM_BYTES - 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE, ACK} state_t;

  state_t                state;
  logic                  last_grant;
  logic [WORD_WIDTH-1:0] word;
  logic [1:0]            byte_idx;
  logic [CNT_W-1:0]      timeout_cnt;
  logic                  pick;
  logic [7:0]            cur_byte;

  // With both requesting, the one that did not own the previous word wins.
  always_comb begin
    pick = 1'b0;
    if (bus.req0_valid && bus.req1_valid)
      pick = ~last_grant;
    else
      pick = bus.req1_valid;
  end

  always_comb begin
    cur_byte = word[7:0];
`ifdef UART_ARB_TAG_EN
    case (byte_idx)
      2'd0:    cur_byte = 8'hA0 | {7'd0, bus.grant};
      2'd1:    cur_byte = word[15:8];
      default: cur_byte = word[7:0];
    endcase
`else
    if (byte_idx == 2'd0)
      cur_byte = word[15:8];
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      last_grant      <= 1'b1;
      word            <= '0;
      byte_idx        <= '0;
      timeout_cnt     <= '0;
      bus.grant       <= 1'b0;
      bus.busy        <= 1'b0;
      bus.tx_start_n  <= 1'b1;
      bus.tx_data     <= 8'd0;
      bus.req0_ack    <= 1'b0;
      bus.req1_ack    <= 1'b0;
      bus.timeout_err <= 1'b0;
    end else begin
      bus.tx_start_n <= 1'b1;
      bus.req0_ack   <= 1'b0;
      bus.req1_ack   <= 1'b0;
      case (state)
        IDLE: begin
          byte_idx <= '0;
          if (bus.req0_valid || bus.req1_valid) begin
            bus.grant <= pick;
            word      <= pick ? bus.req1_word : bus.req0_word;
            bus.busy  <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          if (bus.tx_ready_to_send) begin
            bus.tx_data    <= cur_byte;
            bus.tx_start_n <= 1'b0;
            timeout_cnt    <= '0;
            state          <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          if (!bus.tx_ready_to_send) begin
            state <= WAIT_DONE;
          end else if (timeout_cnt == CNT_LIMIT) begin
            // Drop the word; the requester still holds valid and is re-served later.
            bus.timeout_err <= 1'b1;
            last_grant      <= bus.grant;
            bus.busy        <= 1'b0;
            state           <= IDLE;
          end else begin
            timeout_cnt <= timeout_cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (bus.tx_ready_to_send) begin
            if (byte_idx == LAST_IDX) begin
              bus.req0_ack <= ~bus.grant;
              bus.req1_ack <= bus.grant;
              state        <= ACK;
            end else begin
              byte_idx <= byte_idx + 1'b1;
              state    <= SEND;
            end
          end
        end
        ACK: begin
          last_grant <= bus.grant;
          bus.busy   <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arb.sv
// Randomised scoreboard bench for uart_tx_arb with a behavioural uart_tx model and round-robin reference.
module tb_uart_tx_arb;
`ifdef UART_ARB_TAG_EN
  localparam int NB = 3;
`else
  localparam int NB = 2;
`endif
  localparam int TMO = 64;

  typedef struct packed {
    logic        id;
    logic [15:0] word;
  } ack_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stuck = 1'b0;
  int   frame_left;
  int   n_chk = 0;
  int   n_pass = 0;
  int   byte_seen = 0;
  logic ref_last = 1'b1;
  logic prev_low = 1'b0;
  logic post_ack = 1'b0;

  logic [7:0] exp_bytes[$];
  ack_t       exp_acks[$];
  logic [7:0] rx_buf[$];

  uart_tx_arb_if bus ();

  uart_tx_arb #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h expected=%h", name, act, exp);
  endtask

  // Behavioural uart_tx: accepts a start strobe while ready, then is busy for a random frame time.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.tx_ready_to_send <= 1'b1;
      frame_left <= 0;
    end else if (bus.tx_ready_to_send) begin
      if (!bus.tx_start_n && !stuck) begin
        bus.tx_ready_to_send <= 1'b0;
        frame_left <= int'($urandom_range(2, 6));
      end
    end else if (frame_left == 0) begin
      bus.tx_ready_to_send <= 1'b1;
    end else begin
      frame_left <= frame_left - 1;
    end
  end

  // Byte monitor
  always @(negedge clk) begin
    logic [31:0] exp;
    if (!rst && !bus.tx_start_n) begin
      check("start_width", {31'd0, prev_low}, 32'd0);
      if (!stuck) begin
        exp = (exp_bytes.size() != 0) ? {24'd0, exp_bytes.pop_front()} : 32'hDEAD_BEEF;
        check("tx_byte", {24'd0, bus.tx_data}, exp);
        rx_buf.push_back(bus.tx_data);
        byte_seen++;
      end
    end
    prev_low = !rst && !bus.tx_start_n;
  end

  // Ack monitor
  always @(negedge clk) begin
    ack_t        e;
    logic [31:0] rx_word;
    if (!rst) begin
      if (post_ack) check("busy_after_ack", {31'd0, bus.busy}, 32'd0);
      post_ack = 1'b0;
      if (bus.req0_ack || bus.req1_ack) begin
        check("ack_onehot", {31'd0, bus.req0_ack & bus.req1_ack}, 32'd0);
        rx_word = (rx_buf.size() >= 2) ? {16'd0, rx_buf[rx_buf.size()-2], rx_buf[rx_buf.size()-1]}
                                       : 32'hFFFF_FFFF;
        if (exp_acks.size() != 0) begin
          e = exp_acks.pop_front();
          check("ack_id", {31'd0, bus.req1_ack}, {31'd0, e.id});
          check("rx_word", rx_word, {16'd0, e.word});
        end else begin
          check("ack_unexpected", {31'd0, bus.req1_ack}, 32'd2);
        end
        check("rx_len", rx_buf.size(), NB);
        $display("ack req%0d rx_word %h", bus.req1_ack, rx_word[15:0]);
        rx_buf.delete();
        post_ack = 1'b1;
      end
    end
  end

  function automatic void expect_word(input logic id, input logic [15:0] w);
    ack_t a;
`ifdef UART_ARB_TAG_EN
    exp_bytes.push_back(8'hA0 | {7'd0, id});
`endif
    exp_bytes.push_back(w[15:8]);
    exp_bytes.push_back(w[7:0]);
    a.id = id;
    a.word = w;
    exp_acks.push_back(a);
  endfunction

  // Serve until both valids drop; scrambles each word once after its grant.
  task automatic serve(input bit scr_zero);
    bit scr0 = 0, scr1 = 0;
    int cyc = 0;
    while ((bus.req0_valid || bus.req1_valid) && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (bus.req0_ack) bus.req0_valid = 1'b0;
      if (bus.req1_ack) bus.req1_valid = 1'b0;
      if (bus.busy && !bus.grant && bus.req0_valid && !scr0) begin
        bus.req0_word = scr_zero ? 16'h0000 : 16'($urandom);
        scr0 = 1;
      end
      if (bus.busy && bus.grant && bus.req1_valid && !scr1) begin
        bus.req1_word = scr_zero ? 16'h0000 : 16'($urandom);
        scr1 = 1;
      end
    end
    if (bus.req0_valid || bus.req1_valid) begin
      check("serve_timeout", cyc, 0);
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      exp_bytes.delete();
      exp_acks.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // Reference: round-robin order computed from who asks and who went last.
  task automatic run_round(input bit v0, input bit v1, input logic [15:0] w0,
                           input logic [15:0] w1, input bit scr_zero);
    if (v0 && v1) begin
      if (ref_last) begin expect_word(1'b0, w0); expect_word(1'b1, w1); ref_last = 1'b1; end
      else begin expect_word(1'b1, w1); expect_word(1'b0, w0); ref_last = 1'b0; end
    end else if (v0) begin
      expect_word(1'b0, w0); ref_last = 1'b0;
    end else if (v1) begin
      expect_word(1'b1, w1); ref_last = 1'b1;
    end
    bus.req0_word = w0;
    bus.req1_word = w1;
    bus.req0_valid = v0;
    bus.req1_valid = v1;
    serve(scr_zero);
  endtask

  initial begin
    int cyc;
    int base;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_word = '0;
    bus.req1_word = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_start_n", {31'd0, bus.tx_start_n}, 32'd1);
    check("rst_data", {24'd0, bus.tx_data}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_grant", {31'd0, bus.grant}, 32'd0);
    check("rst_acks", {30'd0, bus.req0_ack, bus.req1_ack}, 32'd0);
    check("rst_tmo", {31'd0, bus.timeout_err}, 32'd0);

    run_round(1'b1, 1'b1, 16'h1234, 16'h5678, 1'b0);
    run_round(1'b1, 1'b1, 16'h0F0F, 16'hF0F0, 1'b0);
    run_round(1'b1, 1'b0, 16'hABCD, 16'h0000, 1'b1);
    run_round(1'b0, 1'b1, 16'h0000, 16'hBEEF, 1'b0);
    for (int r = 0; r < 30; r++) begin
      int sel = int'($urandom_range(1, 3));
      run_round(sel[0], sel[1], 16'($urandom), 16'($urandom), 1'b0);
    end

    // Transmitter never drops ready: expect timeout, no ack, then a clean resend.
    stuck = 1'b1;
    bus.req0_word = 16'h55AA;
    bus.req0_valid = 1'b1;
    cyc = 0;
    while (!bus.timeout_err && cyc < 20 * TMO) begin @(negedge clk); cyc++; end
    check("tmo_err", {31'd0, bus.timeout_err}, 32'd1);
    check("tmo_busy", {31'd0, bus.busy}, 32'd0);
    stuck = 1'b0;
    expect_word(1'b0, 16'h55AA);
    ref_last = 1'b0;
    serve(1'b0);
    check("tmo_sticky", {31'd0, bus.timeout_err}, 32'd1);

    // Asynchronous reset while the last byte is on the line.
    base = byte_seen;
    expect_word(1'b0, 16'hC3E1);
    bus.req0_word = 16'hC3E1;
    bus.req0_valid = 1'b1;
    cyc = 0;
    while (!(byte_seen == base + NB && !bus.tx_ready_to_send) && cyc < 200) begin
      @(negedge clk); cyc++;
    end
    check("rst_mid_reach", {31'd0, bus.tx_ready_to_send}, 32'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_start_n", {31'd0, bus.tx_start_n}, 32'd1);
    check("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_mid_acks", {30'd0, bus.req0_ack, bus.req1_ack}, 32'd0);
    exp_acks.delete();
    exp_bytes.delete();
    rx_buf.delete();
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_tmo", {31'd0, bus.timeout_err}, 32'd0);
    check("rst_mid_grant", {31'd0, bus.grant}, 32'd0);
    ref_last = 1'b1;
    run_round(1'b1, 1'b0, 16'hC3E1, 16'h0000, 1'b0);
    run_round(1'b1, 1'b1, 16'h2468, 16'h1357, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
